// File: rtl/cpu_icache.sv
// Direct-mapped read-only I-cache: hit data at p2 one cycle after p1_pc; a miss stalls p2
// and burst-fills the whole line. Miss penalty is the beat arrival time plus two cycles.
module cpu_icache #(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] p1_pc,
  input  logic        stall,
  input  logic        invalidate,
  output logic [31:0] p2_instr,
  output logic        p2_icache_stall,
  output logic        mem_rd_req,
  output logic [31:0] mem_rd_addr,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data
);
  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAG_LSB = 2 + OFF_W + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;

  typedef enum logic [1:0] {IDLE, FILL, RDWAIT} state_t;

  logic [TAG_W-1:0] tag_ram  [LINES];
  logic [31:0]      data_ram [LINES*LINE_WORDS];

  state_t           state_q, state_d;
  logic [31:0]      p2_addr_q, p2_addr_d;
  logic             lookup_valid_q, lookup_valid_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic             inv_pending_q, inv_pending_d;
  logic [OFF_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [31:0]      mem_rd_addr_q, mem_rd_addr_d;
  logic [TAG_W-1:0] rd_tag_q;
  logic [31:0]      rd_word_q;

  logic [IDX_W-1:0] p1_idx, p2_idx, fill_idx;
  logic [OFF_W-1:0] p1_off;
  logic [TAG_W-1:0] p2_tag, fill_tag;
  logic             hit, data_we, tag_we;

  assign p1_idx   = p1_pc[2+OFF_W +: IDX_W];
  assign p1_off   = p1_pc[2 +: OFF_W];
  assign p2_idx   = p2_addr_q[2+OFF_W +: IDX_W];
  assign p2_tag   = p2_addr_q[31:TAG_LSB];
  assign fill_idx = mem_rd_addr_q[2+OFF_W +: IDX_W];
  assign fill_tag = mem_rd_addr_q[31:TAG_LSB];

  // RAM words are registered alongside p2_addr, so they always describe the p2 line.
  assign hit             = lookup_valid_q && valid_q[p2_idx] && (rd_tag_q == p2_tag);
  assign p2_instr        = hit ? rd_word_q : 32'h0;
  assign p2_icache_stall = lookup_valid_q && (!hit || state_q != IDLE);
  assign mem_rd_req      = (state_q == FILL);
  assign mem_rd_addr     = mem_rd_addr_q;

  always_comb begin
    state_d        = state_q;
    p2_addr_d      = stall ? p2_addr_q : p1_pc;
    lookup_valid_d = 1'b1;
    valid_d        = valid_q;
    inv_pending_d  = inv_pending_q;
    beat_cnt_d     = beat_cnt_q;
    mem_rd_addr_d  = mem_rd_addr_q;
    data_we        = 1'b0;
    tag_we         = 1'b0;
    case (state_q)
      IDLE: begin
        if (lookup_valid_q && !hit) begin
          state_d       = FILL;
          mem_rd_addr_d = p2_addr_q & ~32'(LINE_WORDS*4 - 1);
          beat_cnt_d    = '0;
        end
      end
      FILL: begin
        if (invalidate) inv_pending_d = 1'b1;
        if (mem_rd_valid && !reset) begin
          data_we    = 1'b1;
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == OFF_W'(LINE_WORDS-1)) begin
            tag_we  = 1'b1;
            state_d = RDWAIT;
            if (!inv_pending_q) valid_d[fill_idx] = 1'b1;
          end
        end
      end
      RDWAIT: begin
        state_d       = IDLE;
        inv_pending_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    // Applied last so an invalidate beats a same-cycle fill completion.
    if (invalidate) valid_d = '0;
  end

  always_ff @(posedge clock) begin
    p2_addr_q <= p2_addr_d;
    if (reset) begin
      state_q        <= IDLE;
      lookup_valid_q <= 1'b0;
      valid_q        <= '0;
      inv_pending_q  <= 1'b0;
      beat_cnt_q     <= '0;
      mem_rd_addr_q  <= '0;
    end else begin
      state_q        <= state_d;
      lookup_valid_q <= lookup_valid_d;
      valid_q        <= valid_d;
      inv_pending_q  <= inv_pending_d;
      beat_cnt_q     <= beat_cnt_d;
      mem_rd_addr_q  <= mem_rd_addr_d;
    end
  end

  always_ff @(posedge clock) begin
    rd_tag_q  <= tag_ram[p1_idx];
    rd_word_q <= data_ram[{p1_idx, p1_off}];
    if (data_we) data_ram[{fill_idx, beat_cnt_q}] <= mem_rd_data;
    if (tag_we)  tag_ram[fill_idx] <= fill_tag;
  end

endmodule

// File: tb/tb_cpu_icache.sv
// Randomized bench for cpu_icache: the bench plays the fetch stage and the memory, and
// keeps a line-level model of which lines are resident and what data they hold.
module tb_cpu_icache;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] p1_pc;
  logic        stall_ext;
  logic        stall;
  logic        invalidate;
  logic [31:0] p2_instr;
  logic        p2_icache_stall;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;

  assign stall = stall_ext | p2_icache_stall;

  cpu_icache #(.LINES(64), .LINE_WORDS(4)) dut (
    .clock(clock), .reset(reset), .p1_pc(p1_pc), .stall(stall), .invalidate(invalidate),
    .p2_instr(p2_instr), .p2_icache_stall(p2_icache_stall), .mem_rd_req(mem_rd_req),
    .mem_rd_addr(mem_rd_addr), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: resident lines, their tags and the data last delivered for them.
  bit          mvalid [64];
  logic [21:0] mtag   [64];
  logic [31:0] mdata  [256];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
  endtask

  // inv_beat: -1 none, -2 invalidate on the presentation edge, 0..3 invalidate with that beat
  task automatic fetch(input logic [31:0] addr, input int gap, input int inv_beat);
    int idx, off, fills, n, g;
    logic [21:0] tg;
    logic [31:0] d;
    bit inv_fill;
    idx = int'(addr[9:4]);
    off = int'(addr[3:2]);
    tg  = addr[31:10];
    p1_pc = addr;
    if (inv_beat == -2) begin
      invalidate = 1'b1;
      model_clear();
    end
    step();
    invalidate = 1'b0;
    fills = 0;
    while (!(mvalid[idx] && mtag[idx] == tg) && fills < 3) begin
      inv_fill = (fills == 0) && (inv_beat >= 0);
      check("miss_stall", 32'(p2_icache_stall), 32'd1);
      n = 0;
      while (!mem_rd_req && n < 8) begin
        step();
        n++;
      end
      check("req_latency", n, 1);
      check("fill_addr", mem_rd_addr, {addr[31:4], 4'h0});
      for (int w = 0; w < 4; w++) begin
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        for (int k = 0; k < g; k++) begin
          step();
          check("gap_stall", 32'(p2_icache_stall), 32'd1);
          check("gap_req", 32'(mem_rd_req), 32'd1);
        end
        d = $urandom;
        mem_rd_valid = 1'b1;
        mem_rd_data  = d;
        mdata[idx*4 + w] = d;
        if (inv_fill && w == inv_beat) begin
          invalidate = 1'b1;
          model_clear();
        end
        step();
        mem_rd_valid = 1'b0;
        invalidate   = 1'b0;
      end
      check("rdwait_stall", 32'(p2_icache_stall), 32'd1);
      check("rdwait_req", 32'(mem_rd_req), 32'd0);
      mvalid[idx] = !inv_fill;
      mtag[idx]   = tg;
      step();
      fills++;
    end
    check("hit_stall", 32'(p2_icache_stall), 32'd0);
    check("hit_instr", p2_instr, mdata[idx*4 + off]);
    check("hit_req", 32'(mem_rd_req), 32'd0);
  endtask

  task automatic reset_mid_fill(input logic [31:0] addr);
    int n;
    p1_pc = addr;
    step();
    n = 0;
    while (!mem_rd_req && n < 8) begin
      step();
      n++;
    end
    check("rst_req_seen", 32'(mem_rd_req), 32'd1);
    for (int w = 0; w < 2; w++) begin
      mem_rd_valid = 1'b1;
      mem_rd_data  = $urandom;
      step();
    end
    mem_rd_data = $urandom;
    reset = 1'b1;
    step();
    check("rst_req", 32'(mem_rd_req), 32'd0);
    check("rst_stall", 32'(p2_icache_stall), 32'd0);
    check("rst_instr", p2_instr, 32'h0);
    mem_rd_data = $urandom;
    step();
    check("rst_stall2", 32'(p2_icache_stall), 32'd0);
    mem_rd_valid = 1'b0;
    reset = 1'b0;
    model_clear();
    fetch(addr, 0, -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [21:0] tags [4];
    tags[0] = 22'h0; tags[1] = 22'h1; tags[2] = 22'h3c000; tags[3] = 22'h2a5a5;
    model_clear();
    reset = 1'b1; p1_pc = 32'h0; stall_ext = 1'b0; invalidate = 1'b0;
    mem_rd_valid = 1'b0; mem_rd_data = 32'h0;
    repeat (3) step();
    check("reset_req", 32'(mem_rd_req), 32'd0);
    check("reset_stall", 32'(p2_icache_stall), 32'd0);
    check("reset_instr", p2_instr, 32'h0);
    check("reset_addr", mem_rd_addr, 32'h0);
    reset = 1'b0;

    fetch(32'hffff0000, 0, -1);
    fetch(32'hffff0004, 0, -1);
    fetch(32'hffff0008, 0, -1);
    fetch(32'hffff000c, 0, -1);

    fetch(32'h00000010, 3, -1);
    fetch(32'h00000014, 0, -1);
    fetch(32'h00000018, 0, -1);
    fetch(32'h0000001c, 0, -1);

    fetch(32'h00000000, 0, -1);
    fetch(32'h00000400, 0, -1);
    fetch(32'h00000000, 1, -1);

    fetch(32'h00000020, -1, 1);
    fetch(32'h00000024, 0, -1);
    fetch(32'h00000014, 0, -1);
    fetch(32'h00000028, 0, -2);
    fetch(32'h00000014, 0, -1);
    fetch(32'h00000030, 0, 3);

    reset_mid_fill(32'h00000040);

    for (int i = 0; i < 250; i++) begin
      a = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'b00};
      if ($urandom_range(0, 19) == 0)
        fetch(a, -1, -2);
      else if ($urandom_range(0, 9) == 0)
        fetch(a, -1, int'($urandom_range(0, 3)));
      else
        fetch(a, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
